branch_predictor: RTL and testbench

//   Dynamic branch predictor pairing with the EX-stage branch decision unit: predicts in IF,

---
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, plus EX-stage mispredict detection.
// Optional resolved-branch / mispredict statistics counters are enabled by defining BP_STATS_EN.
`ifndef NOBRANCH
`define NOBRANCH 3'b000
`endif

module branch_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        StallE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] BrTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_f_hit;
    logic             w_e_hit;
    logic             w_is_branch;
    logic             w_upd;
    logic [1:0]       w_e_ctr;

    assign w_f_idx = PCF[IDX_W+1:2];
    assign w_f_tag = PCF[31:IDX_W+2];
    assign w_e_idx = PCE[IDX_W+1:2];
    assign w_e_tag = PCE[31:IDX_W+2];

    assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_e_hit     = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
    assign w_e_ctr     = r_ctr[w_e_idx];
    assign w_is_branch = (BranchTypeE != `NOBRANCH);
    assign w_upd       = w_is_branch && !StallE;

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign PredTakenF  = rst_n && w_f_hit && r_ctr[w_f_idx][1];
    assign PredTargetF = PredTakenF ? r_target[w_f_idx] : (PCF + 32'd4);

    assign MispredictE = rst_n && w_is_branch &&
                         ((BranchE != PredTakenE) || (BranchE && (PredTargetE != BrTargetE)));
    assign CorrectPCE  = BranchE ? BrTargetE : (PCE + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (w_upd) begin
            if (w_e_hit) begin
                if (BranchE) begin
                    r_ctr[w_e_idx] <= (w_e_ctr == 2'b11) ? 2'b11 : w_e_ctr + 2'd1;
                end else begin
                    r_ctr[w_e_idx] <= (w_e_ctr == 2'b00) ? 2'b00 : w_e_ctr - 2'd1;
                end
            end else if (BranchE) begin
                r_valid[w_e_idx] <= 1'b1;
                r_ctr[w_e_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (rst_n && w_upd && BranchE) begin
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= BrTargetE;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count   <= 32'd0;
            r_miss_count <= 32'd0;
        end else if (w_upd) begin
            if (r_br_count != 32'hFFFF_FFFF) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (MispredictE && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign BrCount   = r_br_count;
    assign MissCount = r_miss_count;
`else
    assign BrCount   = 32'd0;
    assign MissCount = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an abstract BTB/counter model held in arrays.
`ifndef NOBRANCH
`define NOBRANCH 3'b000
`endif

module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned IDX_W   = 6;
    localparam logic [2:0]  BEQ     = 3'b001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pcf;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        stall_e;
    logic [2:0]  btype_e;
    logic        branch_e;
    logic [31:0] pce;
    logic [31:0] br_target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        mispredict_e;
    logic [31:0] correct_pce;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-entry valid/tag/target and a counter value 0..3.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_br;
    int unsigned m_miss;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (pcf),
        .PredTakenF  (pred_taken_f),
        .PredTargetF (pred_target_f),
        .StallE      (stall_e),
        .BranchTypeE (btype_e),
        .BranchE     (branch_e),
        .PCE         (pce),
        .BrTargetE   (br_target_e),
        .PredTakenE  (pred_taken_e),
        .PredTargetE (pred_target_e),
        .MispredictE (mispredict_e),
        .CorrectPCE  (correct_pce),
        .BrCount     (br_count),
        .MissCount   (miss_count)
    );

    always #5 clk = ~clk;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_taken(logic [31:0] pc);
        int unsigned i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_next(logic [31:0] pc);
        return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mispredict();
        if (btype_e == `NOBRANCH) return 1'b0;
        if (branch_e != pred_taken_e) return 1'b1;
        return branch_e && (pred_target_e != br_target_e);
    endfunction

    function automatic logic [31:0] m_correct();
        return branch_e ? br_target_e : pce + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [2:0] bt, input logic br,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                          input logic st);
        pce = pc; btype_e = bt; branch_e = br; br_target_e = tgt;
        pred_taken_e = pt; pred_target_e = ptgt; stall_e = st;
    endtask

    task automatic idle_ex();
        set_ex(32'h0, `NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Apply one clock edge to DUT and model; returns at the next falling edge.
    task automatic step();
        int unsigned i;
        @(posedge clk);
        if (rst_n && btype_e != `NOBRANCH && !stall_e) begin
            i = idx_of(pce);
            m_br++;
            if (m_mispredict()) m_miss++;
            if (m_valid[i] && m_tag[i] == tag_of(pce)) begin
                if (branch_e) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = br_target_e;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (branch_e) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(pce);
                m_target[i] = br_target_e;
                m_ctr[i]    = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pcf   = 32'h100;
        set_ex(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
        model_reset();
        #1;
        n_cmp += 3;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL reset_taken got=%0b exp=0", pred_taken_f);
        end
        if (pred_target_f !== 32'h104) begin
            n_err++; $display("FAIL reset_target got=%h exp=00000104", pred_target_f);
        end
        if (mispredict_e !== 1'b0) begin
            n_err++; $display("FAIL reset_mispredict got=%0b exp=0", mispredict_e);
        end
        step();
        step();
        idle_ex();
        rst_n = 1'b1;
        #1;
        n_cmp += 3;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL reset_no_learn got=%0b exp=0", pred_taken_f);
        end
        if (br_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", br_count, miss_count);
        end
        if (correct_pce !== 32'h4) begin
            n_err++; $display("FAIL reset_correct got=%h exp=00000004", correct_pce);
        end
    endtask

    task automatic test_cold_taken();
        set_ex(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
        #1;
        n_cmp += 2;
        if (mispredict_e !== 1'b1) begin
            n_err++; $display("FAIL cold_mispredict got=%0b exp=1", mispredict_e);
        end
        if (correct_pce !== 32'h80) begin
            n_err++; $display("FAIL cold_correct got=%h exp=00000080", correct_pce);
        end
        step();
        idle_ex();
        pcf = 32'h100;
        #1;
        n_cmp += 2;
        if (pred_taken_f !== 1'b1) begin
            n_err++; $display("FAIL cold_pred_taken got=%0b exp=1", pred_taken_f);
        end
        if (pred_target_f !== 32'h80) begin
            n_err++; $display("FAIL cold_pred_target got=%h exp=00000080", pred_target_f);
        end
    endtask

    task automatic test_hysteresis();
        bit outcome [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit expect_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_b;
        logic [31:0] exp_m;
        pcf = 32'h100;
        for (int k = 0; k < 6; k++) begin
            set_ex(32'h100, BEQ, outcome[k], 32'h80, m_taken(32'h100), m_next(32'h100), 1'b0);
            #1;
            n_cmp++;
            if (mispredict_e !== m_mispredict()) begin
                n_err++;
                $display("FAIL hyst_mispredict[%0d] got=%0b exp=%0b", k, mispredict_e,
                         m_mispredict());
            end
            step();
            #1;
            n_cmp++;
            if (pred_taken_f !== expect_t[k]) begin
                n_err++;
                $display("FAIL hyst_taken[%0d] got=%0b exp=%0b", k, pred_taken_f, expect_t[k]);
            end
        end
        idle_ex();
`ifdef BP_STATS_EN
        exp_b = m_br; exp_m = m_miss;
`else
        exp_b = 32'd0; exp_m = 32'd0;
`endif
        n_cmp++;
        if (br_count !== exp_b || miss_count !== exp_m) begin
            n_err++;
            $display("FAIL hyst_stats got=%0d/%0d exp=%0d/%0d", br_count, miss_count, exp_b, exp_m);
        end
    endtask

    task automatic test_target_change();
        set_ex(32'h100, BEQ, 1'b1, 32'h90, 1'b1, 32'h80, 1'b0);
        #1;
        n_cmp += 2;
        if (mispredict_e !== 1'b1) begin
            n_err++; $display("FAIL tgt_mispredict got=%0b exp=1", mispredict_e);
        end
        if (correct_pce !== 32'h90) begin
            n_err++; $display("FAIL tgt_correct got=%h exp=00000090", correct_pce);
        end
        step();
        idle_ex();
        pcf = 32'h100;
        #1;
        n_cmp++;
        if (pred_target_f !== 32'h90) begin
            n_err++; $display("FAIL tgt_next got=%h exp=00000090", pred_target_f);
        end
    endtask

    task automatic test_stall();
        pcf = 32'h400;
        set_ex(32'h400, BEQ, 1'b1, 32'h44, 1'b0, 32'h404, 1'b0);
        step();
        // Not-taken held by stall: counter must stay at 10 until release.
        set_ex(32'h400, BEQ, 1'b0, 32'h44, 1'b1, 32'h44, 1'b1);
        for (int k = 0; k < 3; k++) step();
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b1) begin
            n_err++; $display("FAIL stall_hold_nt got=%0b exp=1", pred_taken_f);
        end
        stall_e = 1'b0;
        step();
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL stall_release_nt got=%0b exp=0", pred_taken_f);
        end
        set_ex(32'h400, BEQ, 1'b1, 32'h44, 1'b0, 32'h404, 1'b1);
        #1;
        n_cmp++;
        if (mispredict_e !== 1'b1) begin
            n_err++; $display("FAIL stall_mispredict_ungated got=%0b exp=1", mispredict_e);
        end
        for (int k = 0; k < 3; k++) step();
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL stall_hold_t got=%0b exp=0", pred_taken_f);
        end
        stall_e = 1'b0;
        step();
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b1) begin
            n_err++; $display("FAIL stall_release_t got=%0b exp=1", pred_taken_f);
        end
        idle_ex();
    endtask

    task automatic test_alias();
        set_ex(32'h200, BEQ, 1'b1, 32'h2A0, 1'b0, 32'h204, 1'b0);
        step();
        idle_ex();
        pcf = 32'h100;
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL alias_evicted got=%0b exp=0", pred_taken_f);
        end
        pcf = 32'h200;
        #1;
        n_cmp++;
        if (pred_target_f !== 32'h2A0) begin
            n_err++; $display("FAIL alias_new got=%h exp=000002a0", pred_target_f);
        end
    endtask

    task automatic test_wrap_nobranch();
        pcf = 32'hFFFF_FFFC;
        set_ex(32'hFFFF_FFFC, BEQ, 1'b0, 32'h10, 1'b1, 32'h10, 1'b0);
        #1;
        n_cmp += 3;
        if (pred_target_f !== 32'h0) begin
            n_err++; $display("FAIL wrap_predtarget got=%h exp=00000000", pred_target_f);
        end
        if (correct_pce !== 32'h0) begin
            n_err++; $display("FAIL wrap_correct got=%h exp=00000000", correct_pce);
        end
        if (mispredict_e !== 1'b1) begin
            n_err++; $display("FAIL wrap_mispredict got=%0b exp=1", mispredict_e);
        end
        step();
        // Non-branch with a stale taken prediction: no flush, no learning.
        pcf = 32'h600;
        set_ex(32'h600, `NOBRANCH, 1'b1, 32'h70, 1'b1, 32'h99, 1'b0);
        #1;
        n_cmp++;
        if (mispredict_e !== 1'b0) begin
            n_err++; $display("FAIL nobranch_mispredict got=%0b exp=0", mispredict_e);
        end
        step();
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL nobranch_no_update got=%0b exp=0", pred_taken_f);
        end
        idle_ex();
    endtask

    task automatic test_random();
        logic [31:0] pool [6] = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1F0, 32'h8000_0100};
        logic [31:0] p;
        for (int k = 0; k < 400; k++) begin
            pcf = pool[$urandom_range(0, 5)];
            p   = pool[$urandom_range(0, 5)];
            set_ex(p, ($urandom_range(0, 4) == 0) ? `NOBRANCH : 3'($urandom_range(1, 7)),
                   1'($urandom_range(0, 1)), {26'h0, 4'($urandom_range(0, 3)), 2'b00},
                   1'b0, 32'h0, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) != 0) begin
                pred_taken_e  = m_taken(p);
                pred_target_e = m_next(p);
            end else begin
                pred_taken_e  = 1'($urandom_range(0, 1));
                pred_target_e = {26'h0, 4'($urandom_range(0, 3)), 2'b00};
            end
            #1;
            n_cmp += 4;
            if (pred_taken_f !== m_taken(pcf)) begin
                n_err++;
                $display("FAIL rnd_taken[%0d] pc=%h got=%0b exp=%0b", k, pcf, pred_taken_f,
                         m_taken(pcf));
            end
            if (pred_target_f !== m_next(pcf)) begin
                n_err++;
                $display("FAIL rnd_target[%0d] pc=%h got=%h exp=%h", k, pcf, pred_target_f,
                         m_next(pcf));
            end
            if (mispredict_e !== m_mispredict()) begin
                n_err++;
                $display("FAIL rnd_mispredict[%0d] got=%0b exp=%0b", k, mispredict_e,
                         m_mispredict());
            end
            if (correct_pce !== m_correct()) begin
                n_err++;
                $display("FAIL rnd_correct[%0d] got=%h exp=%h", k, correct_pce, m_correct());
            end
            step();
        end
        idle_ex();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_b;
        set_ex(32'h500, BEQ, 1'b1, 32'h55C, 1'b0, 32'h504, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        pcf = 32'h100;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL rstmid_taken got=%0b exp=0", pred_taken_f);
        end
        step();
        idle_ex();
        rst_n = 1'b1;
        model_reset();
        pcf = 32'h500;
        #1;
        n_cmp++;
        if (pred_taken_f !== 1'b0) begin
            n_err++; $display("FAIL rstmid_discard got=%0b exp=0", pred_taken_f);
        end
        set_ex(32'h500, BEQ, 1'b1, 32'h55C, 1'b0, 32'h504, 1'b0);
        step();
        idle_ex();
`ifdef BP_STATS_EN
        exp_b = m_br;
`else
        exp_b = 32'd0;
`endif
        #1;
        n_cmp++;
        if (br_count !== exp_b) begin
            n_err++; $display("FAIL rstmid_stats got=%0d exp=%0d", br_count, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_cold_taken();
        test_hysteresis();
        test_target_change();
        test_stall();
        test_alias();
        test_wrap_nobranch();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
